// File: rtl/lsu.sv
// Load/store unit: one access at a time between the execute stage and a simple memory port.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned H/W accesses instead of truncating them to the word.
//
// state | meaning
// IDLE  | ready for a new op from execute
// REQ   | memory request presented, waiting for mem_req_ready
// WAIT  | request taken, waiting for read data or write acknowledge
// DONE  | result held on out_* until writeback takes it
module lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_err,
    output logic        out_misalign
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state, state_nxt;
    logic          r_ren, r_wen;
    logic [2:0]    r_f3;
    logic [31:0]   r_addr, r_wdata;
    logic [TW-1:0] tmr, tmr_nxt;
    logic [31:0]   data_q, data_nxt;
    logic          err_q, err_nxt;
    logic          accept, tmo_hit, acc_mis;
    logic [31:0]   rd_sh, ld_data;
    logic [3:0]    wmask_raw;

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    // Down-counter reaches zero on the TIMEOUT-th cycle spent in REQ+WAIT.
    assign tmo_hit  = (TIMEOUT != 0) && (tmr == '0);

`ifdef LSU_MISALIGN_CHECK_EN
    logic mis_q;

    assign acc_mis = (mem_ren ^ mem_wen) &&
                     (((funct3[1:0] == 2'b01) && addr[0]) ||
                      (funct3[1] && (addr[1:0] != 2'b00)));

    always_ff @(posedge clk) begin
        if (rst)
            mis_q <= 1'b0;
        else if (accept)
            mis_q <= acc_mis;
        else if ((state == DONE) && out_ready)
            mis_q <= 1'b0;
    end

    assign out_misalign = mis_q;
`else
    assign acc_mis      = 1'b0;
    assign out_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_f3    <= 3'b000;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
        end else if (accept) begin
            r_ren   <= mem_ren;
            r_wen   <= mem_wen;
            r_f3    <= funct3;
            r_addr  <= addr;
            r_wdata <= wdata;
        end
    end

    always_comb begin
        wmask_raw = 4'b1111;
        case (r_f3[1:0])
            2'b00:   wmask_raw = 4'b0001 << r_addr[1:0];
            2'b01:   wmask_raw = 4'b0011 << r_addr[1:0];
            default: wmask_raw = 4'b1111;
        endcase
    end

    assign mem_req_valid = (state == REQ);
    assign mem_req_addr  = {r_addr[31:2], 2'b00};
    assign mem_req_wen   = r_wen;
    assign mem_req_wdata = r_wen ? (r_wdata << {r_addr[1:0], 3'b000}) : 32'h0;
    assign mem_req_wmask = r_wen ? wmask_raw : 4'b0000;

    assign rd_sh = mem_resp_data >> {r_addr[1:0], 3'b000};

    always_comb begin
        ld_data = rd_sh;
        case (r_f3)
            3'b000:  ld_data = {{24{rd_sh[7]}}, rd_sh[7:0]};
            3'b001:  ld_data = {{16{rd_sh[15]}}, rd_sh[15:0]};
            3'b100:  ld_data = {24'h0, rd_sh[7:0]};
            3'b101:  ld_data = {16'h0, rd_sh[15:0]};
            default: ld_data = rd_sh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            tmr    <= '0;
            data_q <= 32'h0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            tmr    <= tmr_nxt;
            data_q <= data_nxt;
            err_q  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        data_nxt  = data_q;
        err_nxt   = err_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    data_nxt = 32'h0;
                    err_nxt  = 1'b0;
                    tmr_nxt  = TMR_LOAD;
                    if (mem_ren && mem_wen) begin
                        state_nxt = DONE;
                        err_nxt   = 1'b1;
                    end else if (!mem_ren && !mem_wen) begin
                        state_nxt = DONE;
                        data_nxt  = addr;
                    end else if (acc_mis) begin
                        state_nxt = DONE;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (tmo_hit) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                    data_nxt  = 32'h0;
                end else begin
                    if (tmr != '0)
                        tmr_nxt = tmr - 1'b1;
                    if (mem_req_ready)
                        state_nxt = WAIT;
                end
            end
            WAIT: begin
                // A response arriving on the final cycle still completes the access.
                if (mem_resp_valid) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b0;
                    data_nxt  = r_wen ? 32'h0 : ld_data;
                end else if (tmo_hit) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                    data_nxt  = 32'h0;
                end else if (tmr != '0) begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                    data_nxt  = 32'h0;
                    err_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out_valid = (state == DONE);
    assign out_data  = data_q;
    assign out_err   = err_q;
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles spent in REQ+WAIT before the access is aborted (0 = no timeout).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports in_valid input 1 and in_ready output 1, the upstream handshake from the execute stage.
REQ-005 SHALL have ports mem_ren input 1 and mem_wen input 1, the load and store request flags.
REQ-006 SHALL have port funct3  input  3  RISC-V access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 SHALL have port addr  input  32  ALU result: effective address, or pass-through value for non-memory ops.
REQ-008 SHALL have port wdata  input  32  store data, which is rs2.
REQ-009 SHALL have ports mem_req_valid output 1 and mem_req_ready input 1, the memory request handshake.
REQ-010 SHALL have ports mem_req_addr output 32, mem_req_wen output 1, mem_req_wdata output 32 and mem_req_wmask output 4.
REQ-011 SHALL have ports mem_resp_valid input 1 and mem_resp_data input 32, the memory read response.
REQ-012 SHALL have ports out_valid output 1, out_ready input 1, out_data output 32, out_err output 1 and out_misalign output 1, the writeback handshake and result.

Function
REQ-013 SHALL use FSM states IDLE, REQ, WAIT and DONE; in_ready SHALL be 1 only in IDLE with rst low.
REQ-014 SHALL latch mem_ren, mem_wen, funct3, addr and wdata on in_valid&&in_ready, and SHALL ignore inputs otherwise.
REQ-015 SHALL, on accept with both ren and wen low, go IDLE->DONE with out_data=addr, giving out_valid one cycle after accept.
REQ-016 SHALL, on accept with both ren and wen high, go to DONE with out_err=1 and out_data=0, issuing no memory request.
REQ-017 SHALL, on accept of a load or store, go to REQ; in REQ, mem_req_valid=1 with all request fields held stable until mem_req_ready, then go to WAIT.
REQ-018 SHALL drive mem_req_addr={addr[31:2],2'b00} and mem_req_wen=latched wen.
REQ-019 SHALL, for stores, drive mem_req_wdata=wdata<<(8*addr[1:0]); wmask SHALL be B 0001<<addr[1:0], H 0011<<addr[1:0], W 1111, with bits shifted past bit 3 discarded.
REQ-020 SHALL accept mem_resp_valid only in WAIT (no same-cycle req/resp completion); on it, go to DONE.
REQ-021 SHALL form load out_data as byte/half/word of mem_resp_data>>(8*addr[1:0]), sign-extended for B/H and zero-extended for BU/HU; funct3 011/110/111 SHALL be treated as W.
REQ-022 SHALL give store out_data=0 and SHALL complete a store on mem_resp_valid (write acknowledge).
REQ-023 SHALL have minimum memory latency of accept T -> REQ T+1 -> WAIT T+2 -> DONE T+3.
REQ-024 SHALL count cycles in REQ+WAIT; when the count reaches TIMEOUT (TIMEOUT>0), it SHALL drop mem_req_valid and go to DONE with out_err=1 and out_data=0.
REQ-025 SHALL, in DONE, hold out_valid=1 and stable out_* until out_ready, then go to IDLE; no new accept SHALL occur in that same cycle.
REQ-026 SHALL ignore mem_resp_valid outside WAIT.

Reset
REQ-027 SHALL, with rst high at a clock edge, set state=IDLE, the timeout counter=0, and all outputs 0 (in_ready=0 while rst high).
REQ-028 SHALL, on reset mid-transaction, abandon the access without a response; a late mem_resp_valid SHALL be ignored per REQ-026.

Configuration
REQ-029 SHALL, with macro LSU_MISALIGN_CHECK_EN defined, treat H/HU with addr[0]=1 or W with addr[1:0]!=0 as misaligned, issue no request, and go to DONE one cycle after accept with out_err=1, out_misalign=1 and out_data=0.
REQ-030 SHALL, without LSU_MISALIGN_CHECK_EN, tie out_misalign to 0 and perform misaligned accesses per REQ-018/019/021 (truncated to the word).

Verification
REQ-031 SHALL verify an ALU op: addr=0x1234, ren=wen=0 -> out_valid next cycle with out_data=0x1234, and mem_req_valid never asserted.
REQ-032 SHALL verify an LB: addr=0x80000003, mem_resp_data=0x80FFFFFF -> out_data=0xFFFFFF80; the same access as LBU -> out_data=0x00000080.
REQ-033 SHALL verify an SH: addr=0x102, wdata=0xABCD, with mem_req_ready stalled 3 cycles -> request held stable, mem_req_addr=0x100, wmask=1100, wdata=0xABCD0000.
REQ-034 SHALL verify a timeout: TIMEOUT=4, mem_req_ready=1, resp never arrives -> out_err=1 and out_valid at the 4th REQ+WAIT cycle.
REQ-035 SHALL verify a misaligned LW at addr=0x2 -> with LSU_MISALIGN_CHECK_EN: out_misalign=1 and no request; without it: request to 0x0.
REQ-036 SHALL verify a reset in WAIT followed by a late mem_resp_valid -> FSM in IDLE, out_valid=0, in_ready=1 after rst falls.
